// File: rtl/vector_index_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// nn_seq_pkg
// Shared types and helpers for the vector index sequencer.
//   seq_state_t : sequencer FSM states (IDLE, RUN)
//   seq_width() : index width for a count, never narrower than one bit
// ---------------------------------------------------------------------------
package nn_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // A count of 1 still needs a one-bit index so ports never collapse to
    // zero width.
    function automatic int seq_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/vector_index_sequencer_if.sv
// ---------------------------------------------------------------------------
// vector_index_sequencer_if
// Handshake and index bus between the layer controller / MAC address logic
// (master) and the vector index sequencer (slave).
//   start, en, clear      : controller -> sequencer
//   element_index         : current element within the vector
//   vector_index          : current vector within the layer
//   last_element          : running and sitting on the last element
//   new_vector/layer_done : one-cycle boundary pulses
//   busy                  : sequencer is in RUN
// ---------------------------------------------------------------------------
interface vector_index_sequencer_if #(
    parameter int ELEM_COUNT = 8,
    parameter int VEC_COUNT  = 4
);
    import nn_seq_pkg::*;

    localparam int ELEM_W = seq_width(ELEM_COUNT);
    localparam int VEC_W  = seq_width(VEC_COUNT);

    logic              start;
    logic              en;
    logic              clear;
    logic [ELEM_W-1:0] element_index;
    logic [VEC_W-1:0]  vector_index;
    logic              last_element;
    logic              new_vector;
    logic              layer_done;
    logic              busy;

    modport master (
        output start, en, clear,
        input  element_index, vector_index, last_element,
        input  new_vector, layer_done, busy
    );

    modport slave (
        input  start, en, clear,
        output element_index, vector_index, last_element,
        output new_vector, layer_done, busy
    );

endinterface

// File: rtl/vector_index_sequencer_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Counter that steps 0..MAX and returns to 0 on the increment taken at MAX.
// The wrap is an explicit compare against MAX, so non-power-of-two ranges
// wrap correctly.
//   clock, reset_n : clock, asynchronous active-low reset
//   clear          : synchronous return to 0, overrides inc
//   inc            : advance one step this cycle
//   count          : current value
//   at_max         : count == MAX (combinational)
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (count == MAX_V);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vector_index_sequencer.sv
// ---------------------------------------------------------------------------
// vector_index_sequencer
// Two-level index generator: element_index walks one vector, vector_index
// walks one layer's worth of vectors. Boundary pulses are registered and the
// wrap costs no dead cycle, so a layer is exactly ELEM_COUNT*VEC_COUNT
// enabled cycles.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : start/en/clear in; indices, last_element, new_vector,
//                    layer_done and busy out
// Parameters:
//   ELEM_COUNT, VEC_COUNT : elements per vector, vectors per layer (1..65536)
//   CONTINUOUS            : 0 = back to IDLE after the layer, 1 = keep looping
//   ELEM_W, VEC_W         : derived index widths, leave at default
// ---------------------------------------------------------------------------
module vector_index_sequencer
    import nn_seq_pkg::*;
#(
    parameter int ELEM_COUNT = 8,
    parameter int VEC_COUNT  = 4,
    parameter int CONTINUOUS = 0,
    parameter int ELEM_W     = seq_width(ELEM_COUNT),
    parameter int VEC_W      = seq_width(VEC_COUNT)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    vector_index_sequencer_if.slave     bus
);

    seq_state_t        state_reg;
    logic              new_vector_reg;
    logic              layer_done_reg;

    logic [ELEM_W-1:0] elem_count;
    logic [VEC_W-1:0]  vec_count;
    logic              elem_at_max;
    logic              vec_at_max;

    logic              running;
    logic              elem_inc;
    logic              vec_inc;
    logic              layer_wrap;

    assign running    = (state_reg == RUN);
    assign elem_inc   = running & bus.en;
    // The vector counter only moves on the enabled cycle that consumes the
    // last element; a layer wraps when that also hits the last vector.
    assign vec_inc    = elem_inc & elem_at_max;
    assign layer_wrap = vec_inc & vec_at_max;

    wrap_counter #(
        .MAX (ELEM_COUNT - 1),
        .W   (ELEM_W)
    ) u_elem_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (bus.clear),
        .inc     (elem_inc),
        .count   (elem_count),
        .at_max  (elem_at_max)
    );

    wrap_counter #(
        .MAX (VEC_COUNT - 1),
        .W   (VEC_W)
    ) u_vec_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (bus.clear),
        .inc     (vec_inc),
        .count   (vec_count),
        .at_max  (vec_at_max)
    );

    // State and pulse registers. clear suppresses the pulses even when the
    // same cycle would have been a wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            new_vector_reg <= 1'b0;
            layer_done_reg <= 1'b0;
        end else if (bus.clear) begin
            state_reg      <= IDLE;
            new_vector_reg <= 1'b0;
            layer_done_reg <= 1'b0;
        end else begin
            new_vector_reg <= vec_inc;
            layer_done_reg <= layer_wrap;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Both counters have just wrapped to 0, so IDLE is
                    // entered with clean indices.
                    if (layer_wrap && (CONTINUOUS == 0)) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.element_index = elem_count;
    assign bus.vector_index  = vec_count;
    assign bus.last_element  = running & elem_at_max;
    assign bus.new_vector    = new_vector_reg;
    assign bus.layer_done    = layer_done_reg;
    assign bus.busy          = running;

endmodule
